// File: rtl/eb_rr_arb_ctrl_pkg.sv
// Package for the round-robin arbiter / elastic buffer block.
// Holds the one-hot buffer state encoding and the round-robin pick helper.
package eb_rr_arb_pkg;

  localparam int unsigned MAX_N  = 16;
  localparam int unsigned MAX_SW = 4;

  // One-hot occupancy of the 2-slot buffer
  typedef enum logic [2:0] {
    S_EMPTY = 3'b001,
    S_ONE   = 3'b010,
    S_TWO   = 3'b100
  } state_t;

  // First set request bit at or above ptr, wrapping at n-1 -> 0; one-hot result
  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0]  req,
                                               input logic [MAX_SW-1:0] ptr,
                                               input int unsigned       n);
    logic [MAX_N-1:0]  gnt;
    logic              found;
    logic [MAX_SW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      idx = MAX_SW'((32'(ptr) + i) % n);
      if (!found && (i < n) && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/eb_rr_arb_ctrl_if.sv
// Requester-side and consumer-side handshake bundle of eb_rr_arb_ctrl.
// slave: arbiter view; master: producer/consumer (environment) view.
interface eb_rr_arb_ctrl_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
);
  localparam int unsigned SW = $clog2(N);

  logic [N-1:0]   t_valid;
  logic [N-1:0]   t_ready;
  logic [N*W-1:0] t_data;
  logic [N-1:0]   t_last;
  logic           i_0_valid;
  logic           i_0_ready;
  logic [W-1:0]   i_0_data;
  logic [SW-1:0]  i_0_src;
  logic           i_0_last;

  modport slave (
    input  t_valid, t_data, t_last, i_0_ready,
    output t_ready, i_0_valid, i_0_data, i_0_src, i_0_last
  );

  modport master (
    output t_valid, t_data, t_last, i_0_ready,
    input  t_ready, i_0_valid, i_0_data, i_0_src, i_0_last
  );

endinterface

// File: rtl/eb_rr_arb_ctrl_pick.sv
// Combinational round-robin grant: one-hot grant plus its binary index.
module eb_rr_pick
  import eb_rr_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx
);

  assign gnt = N'(rr_pick(MAX_N'(req), MAX_SW'(ptr), N));

  // One-hot to binary encode of the grant
  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (gnt[k]) gnt_idx = SW'(k);
    end
  end

endmodule

// File: rtl/eb_rr_arb_ctrl.sv
// N-to-1 round-robin arbiter feeding a shared 2-slot elastic buffer.
// Optional packet lock: define EB_RR_ARB_PKT_LOCK_EN to hold the grant on a
// requester until it delivers a beat with t_last set.
module eb_rr_arb_ctrl
  import eb_rr_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  eb_rr_arb_ctrl_if.slave bus
);

  localparam int unsigned SW = $clog2(N);

  state_t        r_state, w_state_nxt;
  logic          w_buf_rdy, w_out_valid;
  logic [SW-1:0] r_ptr;
  logic [N-1:0]  w_req, w_gnt, w_tready;
  logic [SW-1:0] w_gnt_idx;
  logic          w_acc, w_dq;
  logic [W-1:0]  w_in_data;
  logic          w_in_last;

  // Slot 0 is always the head of line and drives the outputs directly
  logic [W-1:0]  r_s0_data, r_s1_data;
  logic [SW-1:0] r_s0_src,  r_s1_src;
  logic          r_s0_last, r_s1_last;

`ifdef EB_RR_ARB_PKT_LOCK_EN
  logic          r_lock;
  logic [SW-1:0] r_lock_idx;

  // While locked only the owning requester may be granted
  assign w_req = r_lock ? (bus.t_valid & (N'(1) << r_lock_idx)) : bus.t_valid;

  // Lock on a non-final beat, release on the final one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_acc) begin
      r_lock     <= ~w_in_last;
      r_lock_idx <= w_gnt_idx;
    end
  end
`else
  assign w_req = bus.t_valid;
`endif

  eb_rr_pick #(.N(N)) u_pick (
    .req     (w_req),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_tready = w_gnt & {N{w_buf_rdy}};
  assign w_acc    = |(bus.t_valid & w_tready);
  assign w_dq     = w_out_valid & bus.i_0_ready;

  // Select the granted requester's beat
  always_comb begin
    w_in_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (w_gnt[k]) w_in_data = bus.t_data[k*W +: W];
    end
  end
  assign w_in_last = |(bus.t_last & w_gnt);

  // Buffer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // Buffer next-state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: if (w_acc)           w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_acc && !w_dq)         w_state_nxt = S_TWO;
        else if (!w_acc && w_dq)    w_state_nxt = S_EMPTY;
      end
      S_TWO:   if (w_dq)            w_state_nxt = S_ONE;
      default:                      w_state_nxt = S_EMPTY;
    endcase
  end

  // Status decode from the registered state only
  always_comb begin
    w_buf_rdy   = 1'b1;
    w_out_valid = 1'b0;
    unique case (r_state)
      S_EMPTY: ;
      S_ONE:   w_out_valid = 1'b1;
      S_TWO: begin
        w_buf_rdy   = 1'b0;
        w_out_valid = 1'b1;
      end
      default: w_buf_rdy = 1'b0;
    endcase
  end

  // Data slots: new beat goes to head if head frees or is empty, else to slot 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0_data <= '0;
      r_s0_src  <= '0;
      r_s0_last <= 1'b0;
      r_s1_data <= '0;
      r_s1_src  <= '0;
      r_s1_last <= 1'b0;
    end else begin
      if (w_acc && ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_dq))) begin
        r_s0_data <= w_in_data;
        r_s0_src  <= w_gnt_idx;
        r_s0_last <= w_in_last;
      end else if ((r_state == S_TWO) && w_dq) begin
        r_s0_data <= r_s1_data;
        r_s0_src  <= r_s1_src;
        r_s0_last <= r_s1_last;
      end
      if (w_acc && (r_state == S_ONE) && !w_dq) begin
        r_s1_data <= w_in_data;
        r_s1_src  <= w_gnt_idx;
        r_s1_last <= w_in_last;
      end
    end
  end

  // Round-robin pointer moves just past the accepted requester
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_ptr <= '0;
    else if (w_acc) r_ptr <= (w_gnt_idx == SW'(N-1)) ? '0 : w_gnt_idx + SW'(1);
  end

  assign bus.t_ready   = w_tready;
  assign bus.i_0_valid = w_out_valid;
  assign bus.i_0_data  = r_s0_data;
  assign bus.i_0_src   = r_s0_src;
  assign bus.i_0_last  = r_s0_last;

endmodule

// File: tb/tb_eb_rr_arb_ctrl.sv
// Bench for eb_rr_arb_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_eb_rr_arb_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic clk;
  logic reset_n;

  eb_rr_arb_ctrl_if #(.N(N), .W(W)) bus_if ();

  eb_rr_arb_ctrl #(.N(N), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of beats, a pointer and an optional lock
  typedef struct {
    logic [W-1:0] d;
    int           src;
    logic         last;
  } beat_t;

  beat_t q[$];
  int    m_ptr;
  bit    m_lock;
  int    m_lk;

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
    logic [N-1:0] g;
    g = '0;
    if (q.size() >= 2) return g;
    if (m_lock) begin
      if (v[m_lk]) g[m_lk] = 1'b1;
      return g;
    end
    for (int i = 0; i < int'(N); i++) begin
      int k;
      k = (m_ptr + i) % int'(N);
      if (v[k]) begin
        g[k] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic do_reset();
    reset_n          = 1'b0;
    bus_if.t_valid   = '0;
    bus_if.t_data    = '0;
    bus_if.t_last    = '0;
    bus_if.i_0_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    q.delete();
    m_ptr  = 0;
    m_lock = 0;
    m_lk   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         rdy;
    logic [N-1:0] exp_tready;
    logic         exp_ov;
    int           exp_src;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp5[5];
    int got[$];
    int b0;
    logic acc0;
    logic [N-1:0] pend;
    logic [W-1:0] pd[N];
    logic         pl[N];
    logic [N-1:0] exp_g;
    logic         dq;

    // Cycle-by-cycle vectors from reset: full rotation, sparse requesters, backpressure
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3};
    tbl[6]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 0};
    tbl[7]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1};
    tbl[8]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 3};
    tbl[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3};
    tbl[11] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 3};
    tbl[12] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 3};
    tbl[13] = '{4'b0100, 1'b1, 4'b0000, 1'b1, 3};
    tbl[14] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};

    // Reset with idle requesters: nothing moves for 10 cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_valid", i), 64'(bus_if.i_0_valid), 64'(0));
      chk($sformatf("idle%0d_tready", i), 64'(bus_if.t_ready), 64'(0));
      tick();
    end

    // Vector table
    do_reset();
    for (int k = 0; k < int'(N); k++) bus_if.t_data[k*W +: W] = 32'h100 + 32'(k);
    bus_if.t_last = '1;
    for (int i = 0; i < 17; i++) begin
      bus_if.t_valid   = tbl[i].valid;
      bus_if.i_0_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_tready", i), 64'(bus_if.t_ready), 64'(tbl[i].exp_tready));
      chk($sformatf("vec%0d_valid", i), 64'(bus_if.i_0_valid), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov)
        chk($sformatf("vec%0d_src", i), 64'(bus_if.i_0_src), 64'(tbl[i].exp_src));
      tick();
    end

    // Single requester fills the buffer under backpressure, then drains in order
    do_reset();
    bus_if.t_last = '1;
    bus_if.t_valid = 4'b0100;
    bus_if.t_data[2*W +: W] = 32'hAAAA_0001;
    @(negedge clk);
    chk("fill_a_tready", 64'(bus_if.t_ready), 64'(4'b0100));
    tick();
    bus_if.t_data[2*W +: W] = 32'hBBBB_0002;
    @(negedge clk);
    chk("fill_b_tready", 64'(bus_if.t_ready), 64'(4'b0100));
    chk("fill_b_data", 64'(bus_if.i_0_data), 64'(32'hAAAA_0001));
    tick();
    bus_if.t_data[2*W +: W] = 32'hCCCC_0003;
    @(negedge clk);
    chk("fill_c_blocked", 64'(bus_if.t_ready), 64'(0));
    tick();
    bus_if.i_0_ready = 1'b1;
    @(negedge clk);
    chk("drain_a_data", 64'(bus_if.i_0_data), 64'(32'hAAAA_0001));
    chk("drain_a_src", 64'(bus_if.i_0_src), 64'(2));
    chk("drain_a_tready", 64'(bus_if.t_ready), 64'(0));
    tick();
    @(negedge clk);
    chk("drain_b_data", 64'(bus_if.i_0_data), 64'(32'hBBBB_0002));
    chk("drain_c_tready", 64'(bus_if.t_ready), 64'(4'b0100));
    tick();
    bus_if.t_valid = '0;
    @(negedge clk);
    chk("drain_c_data", 64'(bus_if.i_0_data), 64'(32'hCCCC_0003));
    chk("drain_c_src", 64'(bus_if.i_0_src), 64'(2));
    tick();
    @(negedge clk);
    chk("drain_empty", 64'(bus_if.i_0_valid), 64'(0));
    tick();

    // Packet: req0 sends 3 beats (last on the 3rd), req1 valid throughout
`ifdef EB_RR_ARB_PKT_LOCK_EN
    exp5 = '{0, 0, 0, 1, 1};
`else
    exp5 = '{0, 1, 0, 1, 0};
`endif
    do_reset();
    bus_if.i_0_ready = 1'b1;
    bus_if.t_data[1*W +: W] = 32'hE1;
    bus_if.t_last[1] = 1'b1;
    b0 = 0;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      bus_if.t_valid = {2'b00, 1'b1, (b0 < 3)};
      bus_if.t_last[0] = (b0 == 2);
      bus_if.t_data[0*W +: W] = 32'hD0 + 32'(b0);
      @(negedge clk);
      if (bus_if.i_0_valid) got.push_back(int'(bus_if.i_0_src));
      acc0 = bus_if.t_ready[0] & bus_if.t_valid[0];
      tick();
      if (acc0) b0++;
    end
    chk("pkt_count", 64'(got.size()), 64'(5));
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("pkt_src%0d", i), 64'(got[i]), 64'(exp5[i]));

    // Reset while the buffer holds two beats
    do_reset();
    bus_if.t_last = '1;
    bus_if.t_valid = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    chk("two_tready", 64'(bus_if.t_ready), 64'(0));
    chk("two_valid", 64'(bus_if.i_0_valid), 64'(1));
    #1 reset_n = 1'b0;
    #1 chk("rst_async_valid", 64'(bus_if.i_0_valid), 64'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus_if.i_0_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 64'(bus_if.t_ready), 64'(4'b0001));
    tick();
    @(negedge clk);
    chk("post_rst_valid", 64'(bus_if.i_0_valid), 64'(1));
    chk("post_rst_src", 64'(bus_if.i_0_src), 64'(0));
    tick();

    // Randomized traffic against the reference model
    do_reset();
    pend = '0;
    for (int k = 0; k < int'(N); k++) begin
      pd[k] = '0;
      pl[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < int'(N); k++) begin
        if (!pend[k] && ($urandom_range(99) < 50)) begin
          pend[k] = 1'b1;
          pd[k]   = $urandom;
          pl[k]   = 1'($urandom_range(1));
          bus_if.t_data[k*W +: W] = pd[k];
          bus_if.t_last[k] = pl[k];
        end
      end
      bus_if.t_valid   = pend;
      bus_if.i_0_ready = ($urandom_range(99) < 65);
      @(negedge clk);
      exp_g = model_grant(pend);
      chk("rnd_tready", 64'(bus_if.t_ready), 64'(exp_g));
      chk("rnd_valid", 64'(bus_if.i_0_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd_data", 64'(bus_if.i_0_data), 64'(q[0].d));
        chk("rnd_src", 64'(bus_if.i_0_src), 64'(q[0].src));
        chk("rnd_last", 64'(bus_if.i_0_last), 64'(q[0].last));
      end
      dq = (q.size() != 0) && bus_if.i_0_ready;
      @(posedge clk);
      if (dq) void'(q.pop_front());
      for (int k = 0; k < int'(N); k++) begin
        if (exp_g[k]) begin
          q.push_back('{pd[k], k, pl[k]});
          m_ptr = (k + 1) % int'(N);
`ifdef EB_RR_ARB_PKT_LOCK_EN
          m_lock = !pl[k];
          m_lk   = k;
`endif
          pend[k] = 1'b0;
        end
      end
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
